// File: rtl/ctrl_types_pkg.sv
// Shared types for the controller request dispatcher: operations, controller status,
// dispatcher FSM states, the request record and default sizing.
package ctrl_types_pkg;

    localparam int unsigned KeyWDef    = 16;
    localparam int unsigned ValWDef    = 32;
    localparam int unsigned DepthDef   = 4;
    localparam int unsigned TimeoutDef = 255;
    localparam int unsigned OpW        = 3;

    typedef enum logic [OpW-1:0] {
        OpNoop   = 3'd0,
        OpRead   = 3'd1,
        OpCreate = 3'd2,
        OpUpdate = 3'd3,
        OpDelete = 3'd4
    } operation_e;

    typedef struct packed {
        logic done;
        logic error;
    } sub_cmd_t;

    typedef enum logic [1:0] {
        DIdle,
        DIssue,
        DWait,
        DResp
    } dispatch_state_e;

    // Request record at the default widths; the FIFO stores the same fields flattened so
    // that non-default KEY_W / VAL_W builds keep the same layout order.
    typedef struct packed {
        operation_e           op;
        logic [KeyWDef-1:0]   key;
        logic [ValWDef-1:0]   value;
    } req_t;

    // Operations that are forwarded to the controller; NOOP and codes 5-7 are answered locally.
    function automatic logic is_ctrl_op(operation_e op);
        return op inside {OpRead, OpCreate, OpUpdate, OpDelete};
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Request FIFO: DEPTH entries (power of 2), registered occupancy count, strict arrival order.
module req_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CntW-1:0]  count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign push_ok = push && (count_q != CntW'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers are PtrW bits wide, so incrementing wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/ctrl_req_dispatcher.sv
// Queues host requests and issues them one at a time to a controller, with a completion
// timeout that aborts the outstanding command and reports a timed-out error response.
module ctrl_req_dispatcher
    import ctrl_types_pkg::*;
#(
    parameter int unsigned KEY_W   = KeyWDef,
    parameter int unsigned VAL_W   = ValWDef,
    parameter int unsigned DEPTH   = DepthDef,
    parameter int unsigned TIMEOUT = TimeoutDef
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [KEY_W-1:0] req_key_i,
    input  logic [VAL_W-1:0] req_value_i,
    output logic             ctrl_start_o,
    output logic [2:0]       ctrl_op_o,
    output logic [KEY_W-1:0] ctrl_key_o,
    output logic [VAL_W-1:0] ctrl_value_o,
    input  logic [1:0]       ctrl_status_i,
    input  logic [VAL_W-1:0] ctrl_rdata_i,
    output logic             ctrl_abort_o,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_error_o,
    output logic             rsp_timeout_o,
    output logic [VAL_W-1:0] rsp_rdata_o,
    output logic             busy_o
);

    localparam int unsigned EntryW   = OpW + KEY_W + VAL_W;
    localparam int unsigned FifoCntW = $clog2(DEPTH + 1);
    localparam int unsigned TmoW     = $clog2(TIMEOUT + 1);

    dispatch_state_e state_q, state_d;

    operation_e       cmd_op_q, cmd_op_d;
    logic [KEY_W-1:0] cmd_key_q, cmd_key_d;
    logic [VAL_W-1:0] cmd_val_q, cmd_val_d;
    logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_tmo_q, rsp_tmo_d;
    logic [VAL_W-1:0] rsp_rdata_q, rsp_rdata_d;

    sub_cmd_t status;
    logic     tmo_expired;

    logic                fifo_push, fifo_pop, fifo_empty;
    logic [EntryW-1:0]   fifo_wdata, fifo_rdata;
    logic [FifoCntW-1:0] fifo_count;
    logic [OpW-1:0]      head_op;
    logic [KEY_W-1:0]    head_key;
    logic [VAL_W-1:0]    head_val;

    assign status = ctrl_status_i;

    // Ready comes only from the registered count: a pop in the same cycle does not free a slot.
    assign req_ready_o = (fifo_count < FifoCntW'(DEPTH));
    assign fifo_push   = req_valid_i && req_ready_o;
    assign fifo_wdata  = {req_op_i, req_key_i, req_value_i};
    assign {head_op, head_key, head_val} = fifo_rdata;

    req_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // The counter value during a wait cycle is the number of wait cycles already elapsed.
    assign tmo_expired = (tmo_cnt_q == TmoW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        cmd_op_d    = cmd_op_q;
        cmd_key_d   = cmd_key_q;
        cmd_val_d   = cmd_val_q;
        tmo_cnt_d   = tmo_cnt_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            DIdle: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    cmd_op_d  = operation_e'(head_op);
                    cmd_key_d = head_key;
                    cmd_val_d = head_val;
                    state_d   = DIssue;
                end
            end
            DIssue: begin
                if (is_ctrl_op(cmd_op_q)) begin
                    tmo_cnt_d = '0;
                    state_d   = DWait;
                end else begin
                    rsp_err_d   = (cmd_op_q != OpNoop);
                    rsp_tmo_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = DResp;
                end
            end
            DWait: begin
                tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                // A completion in the expiry cycle wins over the timeout.
                if (status.done) begin
                    rsp_err_d   = status.error;
                    rsp_tmo_d   = 1'b0;
                    rsp_rdata_d = (cmd_op_q == OpRead) ? ctrl_rdata_i : '0;
                    state_d     = DResp;
                end else if (tmo_expired) begin
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = DResp;
                end
            end
            DResp: begin
                if (rsp_ready_i) state_d = DIdle;
            end
            default: state_d = DIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_op_q    <= OpNoop;
            cmd_key_q   <= '0;
            cmd_val_q   <= '0;
            tmo_cnt_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            cmd_op_q    <= cmd_op_d;
            cmd_key_q   <= cmd_key_d;
            cmd_val_q   <= cmd_val_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        ctrl_start_o  = (state_q == DIssue) && is_ctrl_op(cmd_op_q);
        ctrl_abort_o  = (state_q == DWait) && !status.done && tmo_expired;
        ctrl_op_o     = cmd_op_q;
        ctrl_key_o    = cmd_key_q;
        ctrl_value_o  = cmd_val_q;
        rsp_valid_o   = (state_q == DResp);
        rsp_error_o   = rsp_valid_o && rsp_err_q;
        rsp_timeout_o = rsp_valid_o && rsp_tmo_q;
        rsp_rdata_o   = rsp_valid_o ? rsp_rdata_q : '0;
        busy_o        = !fifo_empty || (state_q != DIdle);
    end

endmodule

// File: tb/tb_ctrl_req_dispatcher.sv
// Directed self-checking bench for ctrl_req_dispatcher with a hand-driven controller.
module tb_ctrl_req_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_key;
    logic [31:0] req_value;
    logic        ctrl_start;
    logic [2:0]  ctrl_op;
    logic [15:0] ctrl_key;
    logic [31:0] ctrl_value;
    logic [1:0]  ctrl_status;
    logic [31:0] ctrl_rdata;
    logic        ctrl_abort;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_error;
    logic        rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int starts = 0;
    int aborts = 0;

    ctrl_req_dispatcher #(
        .KEY_W   (16),
        .VAL_W   (32),
        .DEPTH   (4),
        .TIMEOUT (255)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_key_i     (req_key),
        .req_value_i   (req_value),
        .ctrl_start_o  (ctrl_start),
        .ctrl_op_o     (ctrl_op),
        .ctrl_key_o    (ctrl_key),
        .ctrl_value_o  (ctrl_value),
        .ctrl_status_i (ctrl_status),
        .ctrl_rdata_i  (ctrl_rdata),
        .ctrl_abort_o  (ctrl_abort),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_error_o   (rsp_error),
        .rsp_timeout_o (rsp_timeout),
        .rsp_rdata_o   (rsp_rdata),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ctrl_start) starts <= starts + 1;
        if (ctrl_abort) aborts <= aborts + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [2:0] op, input logic [15:0] key, input logic [31:0] val,
                        output int acc);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_value = val;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout key=%h: ready got 0 required 1", key);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_start(output int s);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ctrl_start && n < 50);
        s = cyc;
        if (!ctrl_start) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: ctrl_start got 0 required 1");
        end
    endtask

    task automatic ctrl_done(input logic err, input logic [31:0] rd, output int m);
        @(negedge clk);
        ctrl_status = {1'b1, err};
        ctrl_rdata  = rd;
        m = cyc;
        @(posedge clk);
        #1;
        ctrl_status = 2'b00;
        ctrl_rdata  = '0;
    endtask

    task automatic wait_rsp(input logic exp_err, input logic exp_tmo, input logic [31:0] exp_rd,
                            input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 500);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== exp_err || rsp_timeout !== exp_tmo ||
            rsp_rdata !== exp_rd) begin
            errors++;
            $display("FAIL %s: valid/err/tmo/rdata got %b/%b/%b/%h required 1/%b/%b/%h", name,
                     rsp_valid, rsp_error, rsp_timeout, rsp_rdata, exp_err, exp_tmo, exp_rd);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", req_ready);
        end
        checks++;
        if ({ctrl_start, ctrl_abort, rsp_valid, rsp_error, rsp_timeout, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: start/abort/valid/err/tmo/busy got %b required 000000",
                     {ctrl_start, ctrl_abort, rsp_valid, rsp_error, rsp_timeout, busy});
        end
        checks++;
        if ({ctrl_op, ctrl_key, ctrl_value, rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: op/key/val/rdata got %h/%h/%h/%h required 0", ctrl_op,
                     ctrl_key, ctrl_value, rsp_rdata);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_read();
        int acc, s, m, st0;
        st0 = starts;
        send(3'd1, 16'h0012, 32'h0, acc);
        wait_start(s);
        checks++;
        if (s !== acc + 2) begin
            errors++;
            $display("FAIL read_start_latency: start cycle got %0d required %0d", s, acc + 2);
        end
        checks++;
        if (ctrl_op !== 3'd1 || ctrl_key !== 16'h0012) begin
            errors++;
            $display("FAIL read_cmd: op/key got %h/%h required 1/0012", ctrl_op, ctrl_key);
        end
        repeat (2) @(negedge clk);
        ctrl_done(1'b0, 32'hDEADBEEF, m);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || cyc !== m + 1) begin
            errors++;
            $display("FAIL read_rsp_latency: valid %b at cycle %0d required 1 at %0d", rsp_valid,
                     cyc, m + 1);
        end
        wait_rsp(1'b0, 1'b0, 32'hDEADBEEF, "read_rsp");
        checks++;
        if (starts - st0 !== 1) begin
            errors++;
            $display("FAIL read_start_count: got %0d required 1", starts - st0);
        end
    endtask

    task automatic test_bad_ops();
        int acc, st0;
        st0 = starts;
        send(3'b110, 16'h0066, 32'h1111_2222, acc);
        wait_rsp(1'b1, 1'b0, 32'h0, "bad_op_rsp");
        send(3'd0, 16'h0000, 32'h3333_4444, acc);
        wait_rsp(1'b0, 1'b0, 32'h0, "noop_rsp");
        checks++;
        if (starts !== st0) begin
            errors++;
            $display("FAIL bad_ops_no_start: start pulses got %0d required 0", starts - st0);
        end
    endtask

    task automatic test_back_to_back();
        int acc_x, s_x, m_x, acc5, s1, s, m, st0;
        int acc [4];
        st0 = starts;
        send(3'd1, 16'h00A0, 32'h0, acc_x);
        wait_start(s_x);
        for (int k = 0; k < 4; k++) begin
            send(3'd3, 16'(k + 1), 32'hC0DE_0000 | 32'(k + 1), acc[k]);
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (acc[k] !== acc[0] + k) begin
                errors++;
                $display("FAIL b2b_accept_%0d: cycle got %0d required %0d", k, acc[k], acc[0] + k);
            end
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full_ready: got %b required 0", req_ready);
        end
        fork
            send(3'd3, 16'd5, 32'hC0DE_0005, acc5);
            begin
                repeat (3) @(negedge clk);
                checks++;
                if (req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_still_full: ready got %b required 0", req_ready);
                end
                ctrl_done(1'b0, 32'h0000_0BAD, m_x);
                wait_rsp(1'b0, 1'b0, 32'h0000_0BAD, "b2b_first_rsp");
                wait_start(s1);
            end
        join
        checks++;
        if (acc5 !== m_x + 3) begin
            errors++;
            $display("FAIL b2b_fifth_accept: cycle got %0d required %0d", acc5, m_x + 3);
        end
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) wait_start(s);
            checks++;
            if (ctrl_key !== 16'(k) || ctrl_op !== 3'd3 || ctrl_value !== (32'hC0DE_0000 | 32'(k)))
            begin
                errors++;
                $display("FAIL b2b_order_%0d: op/key/val got %h/%h/%h required 3/%h/%h", k,
                         ctrl_op, ctrl_key, ctrl_value, 16'(k), 32'hC0DE_0000 | 32'(k));
            end
            ctrl_done(1'b0, 32'h5555_0000, m);
            wait_rsp(1'b0, 1'b0, 32'h0, "b2b_update_rsp");
        end
        checks++;
        if (starts - st0 !== 6) begin
            errors++;
            $display("FAIL b2b_start_count: got %0d required 6", starts - st0);
        end
    endtask

    task automatic test_timeout();
        int acc, s, a, n, ab0;
        ab0 = aborts;
        send(3'd2, 16'h0BEE, 32'hFACE_0001, acc);
        wait_start(s);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ctrl_abort && n < 300);
        a = cyc;
        checks++;
        if (ctrl_abort !== 1'b1 || a !== s + 255) begin
            errors++;
            $display("FAIL timeout_abort_cycle: abort %b at %0d required 1 at %0d", ctrl_abort, a,
                     s + 255);
        end
        @(negedge clk);
        checks++;
        if (ctrl_abort !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after: abort/valid got %b/%b required 0/1", ctrl_abort,
                     rsp_valid);
        end
        wait_rsp(1'b1, 1'b1, 32'h0, "timeout_rsp");
        checks++;
        if (aborts - ab0 !== 1) begin
            errors++;
            $display("FAIL timeout_abort_count: got %0d required 1", aborts - ab0);
        end
    endtask

    task automatic test_done_error_hold();
        int acc, s, m;
        send(3'd4, 16'h0D0D, 32'h0, acc);
        wait_start(s);
        checks++;
        if (ctrl_op !== 3'd4) begin
            errors++;
            $display("FAIL delete_cmd_op: got %h required 4", ctrl_op);
        end
        @(negedge clk);
        ctrl_status = 2'b01;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL error_without_done: rsp_valid got %b required 0", rsp_valid);
        end
        ctrl_status = 2'b00;
        ctrl_done(1'b1, 32'h0000_1234, m);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_timeout !== 1'b0 ||
                rsp_rdata !== 32'h0) begin
                errors++;
                $display("FAIL done_error_hold_%0d: valid/err/tmo/rdata got %b/%b/%b/%h required 1/1/0/0",
                         i, rsp_valid, rsp_error, rsp_timeout, rsp_rdata);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_error_release: rsp_valid got %b required 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        int acc, s, ab0, st0;
        send(3'd1, 16'h0077, 32'h0, acc);
        wait_start(s);
        for (int k = 0; k < 3; k++) send(3'd3, 16'h0100 + 16'(k), 32'h0, acc);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_before: got %b required 1", busy);
        end
        ab0 = aborts;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 ||
            {ctrl_start, ctrl_abort, rsp_valid, rsp_error, rsp_timeout} !== 5'b0 ||
            {ctrl_op, ctrl_key, ctrl_value, rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ready/busy/start/abort/valid got %b/%b/%b/%b/%b required 1/0/0/0/0",
                     req_ready, busy, ctrl_start, ctrl_abort, rsp_valid);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        st0 = starts;
        repeat (10) @(negedge clk);
        checks++;
        if (starts !== st0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_discard: starts/busy got %0d/%b required 0/0", starts - st0,
                     busy);
        end
        checks++;
        if (aborts !== ab0) begin
            errors++;
            $display("FAIL mid_reset_no_abort: abort pulses got %0d required 0", aborts - ab0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_op      = '0;
        req_key     = '0;
        req_value   = '0;
        ctrl_status = 2'b00;
        ctrl_rdata  = '0;
        rsp_ready   = 1'b0;
        test_reset();
        test_single_read();
        test_bad_ops();
        test_back_to_back();
        test_timeout();
        test_done_error_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
